// File: rtl/divlut_pkg.sv
// rtl/divlut_pkg.sv - shared constants and loader state type for the reciprocal LUT fill
package divlut_pkg;

  localparam int DIVLUT_DEPTH = 2048;
  localparam int DIVLUT_W     = 11;
  localparam int DIVLUT_SAT   = 2047;

  typedef enum logic [1:0] {
    LD_IDLE,
    LD_CALC,
    LD_WRITE,
    LD_DONE
  } divlut_ld_state_t;

endpackage

// File: rtl/recip_serdiv.sv
// rtl/recip_serdiv.sv - bit-serial restoring divider, one quotient bit per cycle, MSB first
module recip_serdiv
  import divlut_pkg::*;
#(
  parameter int RECIP_SHIFT = 21
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [RECIP_SHIFT:0]  numerator,
  input  logic [DIVLUT_W-1:0]   divisor,
  output logic [RECIP_SHIFT:0]  quotient,
  output logic                  q_valid
);

  localparam int QW = RECIP_SHIFT + 1;
  localparam int CW = $clog2(QW + 1);

  logic [QW-1:0]       num_sr;
  logic [11:0]         rem;
  logic [DIVLUT_W-1:0] dvsr;
  logic [CW-1:0]       cnt;

  logic [11:0]         step_rem_in;
  logic                step_bit_in;
  logic [DIVLUT_W-1:0] step_dvsr;
  logic [12:0]         trial;
  logic [11:0]         diff;
  logic                step_q;
  logic [11:0]         step_rem;

  // The load cycle already performs the first iteration, so the remaining
  // RECIP_SHIFT iterations run from the shift register.
  always_comb begin
    step_rem_in = load ? 12'd0 : rem;
    step_bit_in = load ? numerator[QW-1] : num_sr[QW-1];
    step_dvsr   = load ? divisor : dvsr;
    trial       = {step_rem_in, step_bit_in};
    step_q      = (trial >= {2'b00, step_dvsr});
    diff        = trial[11:0] - {1'b0, step_dvsr};
    step_rem    = step_q ? diff : trial[11:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      num_sr   <= '0;
      rem      <= '0;
      dvsr     <= '0;
      cnt      <= '0;
      quotient <= '0;
      q_valid  <= 1'b0;
    end else begin
      q_valid <= 1'b0;
      if (load) begin
        rem      <= step_rem;
        num_sr   <= {numerator[QW-2:0], 1'b0};
        dvsr     <= divisor;
        quotient <= {{(QW-1){1'b0}}, step_q};
        cnt      <= CW'(QW - 1);
      end else if (cnt != '0) begin
        rem      <= step_rem;
        num_sr   <= {num_sr[QW-2:0], 1'b0};
        quotient <= {quotient[QW-2:0], step_q};
        cnt      <= cnt - CW'(1);
        q_valid  <= (cnt == CW'(1));
      end
    end
  end

endmodule

// File: rtl/divlut_loader.sv
// rtl/divlut_loader.sv - fills the 2048-entry reciprocal LUT in address order and owns its run input
module divlut_loader
  import divlut_pkg::*;
#(
  parameter int RECIP_SHIFT = 21
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                lut_run,
  output logic [DIVLUT_W-1:0] lut_wr_data,
  output logic                lut_wr_en
);

  localparam int QW = RECIP_SHIFT + 1;
  localparam logic [QW-1:0] NUMER = {1'b1, {RECIP_SHIFT{1'b0}}};
  localparam logic [DIVLUT_W-1:0] IDX_LAST = DIVLUT_W'(DIVLUT_DEPTH - 1);

  divlut_ld_state_t    state, state_n;
  logic [DIVLUT_W-1:0] idx, idx_n;
  logic [DIVLUT_W-1:0] wr_data_n;
  logic                div_load;
  logic [DIVLUT_W-1:0] div_divisor;
  logic [QW-1:0]       quotient;
  logic                q_valid;

  recip_serdiv #(
    .RECIP_SHIFT(RECIP_SHIFT)
  ) u_serdiv (
    .clk       (clk),
    .reset     (reset),
    .load      (load_gate(div_load)),
    .numerator (NUMER),
    .divisor   (div_divisor),
    .quotient  (quotient),
    .q_valid   (q_valid)
  );

  function automatic logic load_gate(input logic l);
    return l;
  endfunction

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    wr_data_n   = lut_wr_data;
    div_load    = 1'b0;
    div_divisor = idx;
    case (state)
      LD_IDLE: begin
        if (start) begin
          state_n     = LD_CALC;
          idx_n       = '0;
          div_load    = 1'b1;
          div_divisor = '0;
        end
      end
      LD_CALC: begin
        if (q_valid) begin
          state_n   = LD_WRITE;
          wr_data_n = (quotient > QW'(DIVLUT_SAT)) ? DIVLUT_W'(DIVLUT_SAT)
                                                   : quotient[DIVLUT_W-1:0];
        end
      end
      LD_WRITE: begin
        idx_n = idx + DIVLUT_W'(1);
        if (idx == IDX_LAST) begin
          state_n = LD_DONE;
        end else begin
          state_n     = LD_CALC;
          div_load    = 1'b1;
          div_divisor = idx + DIVLUT_W'(1);
        end
      end
      LD_DONE: begin
        state_n = LD_IDLE;
      end
      default: begin
        state_n = LD_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= LD_IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      lut_run     <= 1'b1;
      lut_wr_en   <= 1'b0;
      lut_wr_data <= '0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      busy        <= (state_n != LD_IDLE);
      done        <= (state_n == LD_DONE);
      lut_run     <= (state_n == LD_IDLE) || (state_n == LD_DONE);
      lut_wr_en   <= (state_n == LD_WRITE);
      lut_wr_data <= wr_data_n;
    end
  end

endmodule

// File: tb/tb_divlut_loader.sv
// tb/tb_divlut_loader.sv - directed self-checking bench for divlut_loader at RECIP_SHIFT 21 and 12
module tb_divlut_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, start_a, busy_a, done_a, run_a, wr_en_a;
  logic [10:0] wr_data_a;
  logic        reset_b, start_b, busy_b, done_b, run_b, wr_en_b;
  logic [10:0] wr_data_b;

  divlut_loader u_dut_a (
    .clk         (clk),
    .reset       (reset_a),
    .start       (start_a),
    .busy        (busy_a),
    .done        (done_a),
    .lut_run     (run_a),
    .lut_wr_data (wr_data_a),
    .lut_wr_en   (wr_en_a)
  );

  divlut_loader #(.RECIP_SHIFT(12)) u_dut_b (
    .clk         (clk),
    .reset       (reset_b),
    .start       (start_b),
    .busy        (busy_b),
    .done        (done_b),
    .lut_run     (run_b),
    .lut_wr_data (wr_data_b),
    .lut_wr_en   (wr_en_b)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int ref_val(input int s, input int i);
    longint q;
    if (i == 0) return 2047;
    q = (longint'(1) << s) / i;
    return (q > 2047) ? 2047 : int'(q);
  endfunction

  // strobe recorders
  logic [10:0] ent_a [4096];
  int          t_a   [4096];
  int          n_a = 0;
  int          viol_a = 0;
  logic        prev_wr_a = 1'b0;
  logic [10:0] ent_b [4096];
  int          t_b   [4096];
  int          n_b = 0;
  int          viol_b = 0;
  logic        prev_wr_b = 1'b0;

  always @(negedge clk) begin
    if (wr_en_a) begin
      if (run_a || prev_wr_a) viol_a++;
      if (n_a < 4096) begin
        ent_a[n_a] = wr_data_a;
        t_a[n_a]   = cyc;
      end
      n_a++;
    end
    prev_wr_a = wr_en_a;
    if (wr_en_b) begin
      if (run_b || prev_wr_b) viol_b++;
      if (n_b < 4096) begin
        ent_b[n_b] = wr_data_b;
        t_b[n_b]   = cyc;
      end
      n_b++;
    end
    prev_wr_b = wr_en_b;
  end

  // table model fed by DUT A: pointer clears while run=1
  logic [10:0] mem [2048];
  logic [10:0] wptr = '0;
  logic [10:0] rd_addr = '0;
  logic [10:0] rd_data;

  always @(posedge clk) begin
    if (run_a) wptr <= '0;
    else if (wr_en_a) begin
      mem[wptr] <= wr_data_a;
      wptr      <= wptr + 11'd1;
    end
    rd_data <= mem[rd_addr];
  end

  task automatic read_chk(input string tag, input int addr, input int exp);
    @(posedge clk); #1 rd_addr = 11'(addr);
    @(posedge clk); #1 check(tag, rd_data, exp);
  endtask

  task automatic run_a_thread();
    int c0, k, errs;
    @(posedge clk); #1 start_a = 1'b1; c0 = cyc;
    @(posedge clk); #1 start_a = 1'b0;
    check("a_busy_c1", busy_a, 1);
    check("a_run_c1", run_a, 0);
    k = 0;
    while (n_a < 500 && k < 20000) begin @(posedge clk); #1; k++; end
    check("a_reach_500", (n_a >= 500), 1);
    start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    k = 0;
    while (!done_a && k < 60000) begin @(posedge clk); #1; k++; end
    check("a_done_seen", done_a, 1);
    check("a_done_cycle", cyc - c0, 47105);
    check("a_done_run", run_a, 1);
    check("a_done_busy", busy_a, 1);
    @(posedge clk); #1;
    check("a_busy_after", busy_a, 0);
    check("a_done_pulse", done_a, 0);
    check("a_strobes", n_a, 2048);
    errs = 0;
    for (int i = 0; i < 2048; i++) if (t_a[i] - c0 != (i + 1) * 23) errs++;
    check("a_spacing_errs", errs, 0);
    errs = 0;
    for (int i = 0; i < 2048; i++) if (int'(ent_a[i]) != ref_val(21, i)) errs++;
    check("a_value_errs", errs, 0);
    check("a_e0", ent_a[0], 2047);
    check("a_e1024", ent_a[1024], 2047);
    check("a_e1025", ent_a[1025], 2046);
    check("a_e1536", ent_a[1536], 1365);
    check("a_e2047", ent_a[2047], 1024);
    check("a_wr_viol", viol_a, 0);
  endtask

  task automatic run_b_thread();
    int c1, k, errs, base;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    k = 0;
    while (n_b < 700 && k < 20000) begin @(posedge clk); #1; k++; end
    check("b_reach_700", (n_b >= 700), 1);
    reset_b = 1'b1;
    @(posedge clk); #1 reset_b = 1'b0;
    check("b_rst_run", run_b, 1);
    check("b_rst_busy", busy_b, 0);
    check("b_rst_wr_en", wr_en_b, 0);
    base = n_b;
    repeat (5) @(posedge clk);
    #1 check("b_no_strobe", n_b, base);
    start_b = 1'b1; c1 = cyc;
    @(posedge clk); #1 start_b = 1'b0;
    check("b_busy_c1", busy_b, 1);
    k = 0;
    while (!done_b && k < 35000) begin @(posedge clk); #1; k++; end
    check("b_done_seen", done_b, 1);
    check("b_done_cycle", cyc - c1, 2048 * 14 + 1);
    check("b_strobes", n_b - base, 2048);
    errs = 0;
    for (int i = 0; i < 2048; i++) if (t_b[base + i] - c1 != (i + 1) * 14) errs++;
    check("b_spacing_errs", errs, 0);
    errs = 0;
    for (int i = 0; i < 2048; i++) if (int'(ent_b[base + i]) != ref_val(12, i)) errs++;
    check("b_value_errs", errs, 0);
    check("b_e0", ent_b[base], 2047);
    check("b_e2", ent_b[base + 2], 2047);
    check("b_e3", ent_b[base + 3], 1365);
    check("b_e2047", ent_b[base + 2047], 2);
    check("b_wr_viol", viol_b, 0);
  endtask

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    start_a = 1'b1; start_b = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_a = 1'b0; reset_b = 1'b0; start_a = 1'b0; start_b = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("idle_run_a", run_a, 1);
    check("idle_busy_a", busy_a, 0);
    check("idle_done_a", done_a, 0);
    check("idle_data_a", wr_data_a, 0);
    check("idle_strobes_a", n_a, 0);
    check("idle_run_b", run_b, 1);
    check("idle_busy_b", busy_b, 0);
    check("idle_strobes_b", n_b, 0);

    fork
      run_a_thread();
      run_b_thread();
    join

    read_chk("rd_0", 0, 2047);
    read_chk("rd_1024", 1024, 2047);
    read_chk("rd_1025", 1025, 2046);
    read_chk("rd_2047", 2047, 1024);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divlut_loader.md
# divlut_loader

Sequencer that fills the 2048-entry, 11-bit reciprocal lookup table after reset or on software request. It computes each entry with a bit-serial restoring divider and streams the results in address order into the table's write port. It owns the table's `run` input, so it holds the table in load mode for the whole fill and returns it to normal operation only after the last entry is written.

## Interface
Parameters:
- `RECIP_SHIFT`, default 21: numerator exponent; entry i = min(2047, floor(2^RECIP_SHIFT / i)); legal range 11..30.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to (re)load the table; sampled only in IDLE.
- `busy`  out  1  high from the cycle after an accepted `start` through the DONE cycle.
- `done`  out  1  one-cycle pulse when the last entry has been written.
- `lut_run`  out  1  drives the table's `run`; low only while loading.
- `lut_wr_data`  out  11  entry value.
- `lut_wr_en`  out  1  one-cycle write strobe; the table advances its write address on each strobe.

## Operation
- States:
  - IDLE: `lut_run`=1, `busy`=0.
  - CALC: divider iterating.
  - WRITE: `lut_wr_en`=1.
  - DONE.
- IDLE -> CALC on `start`:
  - `idx` <= 0.
  - `lut_run` <= 0.
  - Divider loaded with numerator 2^RECIP_SHIFT and divisor `idx`.
- CALC:
  - Restoring division, one quotient bit per cycle, MSB first, RECIP_SHIFT+1 cycles.
  - Remainder 12 bits; quotient RECIP_SHIFT+1 bits.
  - After the final iteration -> WRITE.
- WRITE:
  - `lut_wr_data` = quotient > 2047 ? 2047 : quotient[10:0].
  - `idx` increments; 11-bit, wraps 2047 -> 0.
  - If `idx` was 2047 -> DONE, else -> CALC with the new divisor.
- Divisor 0 is not special-cased. The divider's all-ones quotient saturates, so entry 0 = 2047.
- DONE: `lut_run` <= 1, `done`=1 for one cycle, then -> IDLE.
- `lut_run` is high in IDLE and after reset. The table's write pointer therefore clears before every load, because it resets while run=1.
- `start` in any state other than IDLE is ignored; there is no restart mid-load.
- Reset mid-load:
  - Returns to IDLE immediately; `lut_run`=1, no further writes.
  - Table contents are undefined until a complete load finishes.
- `reset` and `start` in the same cycle: reset wins, and the start is lost.

## Timing
- Reset values: `busy`=0, `done`=0, `lut_run`=1, `lut_wr_en`=0, `lut_wr_data`=0, state IDLE, `idx`=0.
- All outputs are registered.
- Per entry: RECIP_SHIFT+2 cycles (RECIP_SHIFT+1 CALC cycles plus 1 WRITE cycle); 23 cycles at the default.
- Taking `start` high at cycle 0:
  - `busy`=1 and `lut_run`=0 from cycle 1.
  - Entry k strobes at cycle (k+1)·(RECIP_SHIFT+2).
  - Last strobe at cycle 2048·(RECIP_SHIFT+2), which is 47104 at the default.
  - `done`=1 and `lut_run`=1 at cycle 2048·(RECIP_SHIFT+2)+1.
  - `busy`=0 the cycle after that.
- `lut_wr_en` is never high on two consecutive cycles.
- `lut_wr_en` is never high while `lut_run`=1.
- `lut_wr_data` holds its value until the next WRITE.
- Downstream consumers must not read the table while `busy`=1.

## Structure
- Shared `divlut_pkg`:
  - `DIVLUT_DEPTH`=2048.
  - `DIVLUT_W`=11.
  - `DIVLUT_SAT`=2047.
  - Loader state enum `divlut_ld_state_t`.
- Sub-module `recip_serdiv`: bit-serial restoring divider.
  - Inputs: `load` pulse, numerator, divisor.
  - Outputs: quotient, `q_valid` pulse after RECIP_SHIFT+1 cycles.
  - Parameterised by RECIP_SHIFT.
- The loader FSM, `idx` counter and saturation logic stay in `divlut_loader`.

## Test plan
- Reset, idle 10 cycles. Required: `lut_run`=1, `busy`=0, no `lut_wr_en`; `start` during reset is ignored.
- Single `start` at default RECIP_SHIFT. Required:
  - Exactly 2048 strobes, 23 cycles apart.
  - Entries 0..1024 = 2047.
  - Entry 1025 = 2046.
  - Entry 1536 = 1365.
  - Entry 2047 = 1024.
  - `done` one cycle after the last strobe.
- Drive the table model from the loader outputs, then read addresses 0, 1024, 1025 and 2047 with `lut_run`=1. Required: reads return 2047, 2047, 2046, 1024 with 1-cycle latency.
- Pulse `start` again at entry 500 of a load. Required: ignored; total strobes still 2048; `done` at cycle 47105.
- Reset at entry 700, then `start`. Required:
  - `lut_run` high the cycle after reset; no strobes until the new start.
  - The new load writes entry 0 = 2047 first and completes with all 2048 correct values.
- RECIP_SHIFT=12. Required:
  - Strobe spacing 14 cycles.
  - Entry 2 = 2047, entry 3 = 1365, entry 2047 = 2.
